// File: rtl/reg_dump_serializer_if.sv
// Bundle of control, register-file read port and serial stream signals for reg_dump_serializer.
// The master side is the serializer itself; the slave side is the register file, the requester and the downstream sink.
interface reg_dump_serializer_if #(
  parameter int SIZE = 32
);
  logic            start;
  logic            abort;
  logic [3:0]      first_reg;
  logic [3:0]      last_reg;
  logic [3:0]      r_sel;
  logic [SIZE-1:0] r_value;
  logic            ser_out;
  logic            ser_valid;
  logic            ser_frame;
  logic            ser_ready;
  logic            busy;
  logic            done;

  modport master (
    input  start, abort, first_reg, last_reg, r_value, ser_ready,
    output r_sel, ser_out, ser_valid, ser_frame, busy, done
  );

  modport slave (
    output start, abort, first_reg, last_reg, r_value, ser_ready,
    input  r_sel, ser_out, ser_valid, ser_frame, busy, done
  );
endinterface

// File: rtl/reg_dump_serializer.sv
// Walks a contiguous (wrapping) register range through one read select and shifts each word out MSB-first.
// Every output comes directly from a flop, so the downstream sees glitch-free stream signals.
module reg_dump_serializer #(
  parameter int SIZE     = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_dump_serializer_if.master  bus
);
  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state;
  logic [3:0]      r_sel;
  logic [3:0]      last_q;
  logic [SIZE-1:0] shift;
  logic [CW-1:0]   cnt;
  logic            ser_out;
  logic            ser_valid;
  logic            ser_frame;
  logic            busy;
  logic            done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r_sel     <= '0;
      last_q    <= '0;
      shift     <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_frame <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (state == IDLE) begin
      // abort outranks start, so a simultaneous request is dropped
      if (bus.start && !bus.abort) begin
        last_q <= bus.last_reg;
        r_sel  <= bus.first_reg;
        busy   <= 1'b1;
        state  <= LOAD;
      end
    end else if (bus.abort) begin
      // r_sel deliberately keeps its value so a debugger can see where the dump stopped
      state     <= IDLE;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_frame <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          shift     <= bus.r_value;
          cnt       <= CW'(SIZE - 1);
          ser_out   <= bus.r_value[SIZE-1];
          ser_valid <= 1'b1;
          ser_frame <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (bus.ser_ready) begin
            if (cnt != '0) begin
              shift     <= shift << 1;
              cnt       <= cnt - 1'b1;
              ser_out   <= shift[SIZE-2];
              ser_frame <= 1'b0;
            end else begin
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              ser_frame <= 1'b0;
              if (r_sel == last_q) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                r_sel <= (r_sel == 4'(NUM_REGS - 1)) ? 4'd0 : r_sel + 4'd1;
                state <= LOAD;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r_sel     = r_sel;
  assign bus.ser_out   = ser_out;
  assign bus.ser_valid = ser_valid;
  assign bus.ser_frame = ser_frame;
  assign bus.busy      = busy;
  assign bus.done      = done;
endmodule
